// File: rtl/vc_sram_arbiter_1rw.sv
// Round-robin arbiter sharing one 1rw SRAM (registered read) between two val/rdy requesters.
// One access in flight; the response is routed back to the requester that owns it.
module vc_sram_arbiter_1rw #(
   parameter int unsigned p_data_nbits  = 32,
   parameter int unsigned p_num_entries = 256,
   localparam int unsigned c_addr_nbits  = $clog2(p_num_entries),
   localparam int unsigned c_data_nbytes = (p_data_nbits + 7) / 8
) (
   input  logic                     clk,
   input  logic                     reset,

   input  logic                     req0_val,
   output logic                     req0_rdy,
   input  logic                     req0_type,
   input  logic [c_addr_nbits-1:0]  req0_addr,
   input  logic [p_data_nbits-1:0]  req0_data,
   input  logic [c_data_nbytes-1:0] req0_byte_en,

   input  logic                     req1_val,
   output logic                     req1_rdy,
   input  logic                     req1_type,
   input  logic [c_addr_nbits-1:0]  req1_addr,
   input  logic [p_data_nbits-1:0]  req1_data,
   input  logic [c_data_nbytes-1:0] req1_byte_en,

   output logic                     resp0_val,
   input  logic                     resp0_rdy,
   output logic                     resp0_type,
   output logic [p_data_nbits-1:0]  resp0_data,

   output logic                     resp1_val,
   input  logic                     resp1_rdy,
   output logic                     resp1_type,
   output logic [p_data_nbits-1:0]  resp1_data,

   output logic                     sram_read_en,
   output logic [c_addr_nbits-1:0]  sram_read_addr,
   input  logic [p_data_nbits-1:0]  sram_read_data,
   output logic                     sram_write_en,
   output logic [c_data_nbytes-1:0] sram_write_byte_en,
   output logic [c_addr_nbits-1:0]  sram_write_addr,
   output logic [p_data_nbits-1:0]  sram_write_data
);

   typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

   state_e                  state_q, state_d;
   logic                    owner_q, owner_d;  // 0 = req0, 1 = req1
   logic                    type_q, type_d;
   logic                    prio_q, prio_d;
   logic [p_data_nbits-1:0] buf_q, buf_d;

   logic                     any_val;
   logic                     winner;
   logic                     win_type;
   logic [c_addr_nbits-1:0]  win_addr;
   logic [p_data_nbits-1:0]  win_data;
   logic [c_data_nbytes-1:0] win_byte_en;
   logic                     owner_resp_rdy;
   logic                     resp_val;
   logic [p_data_nbits-1:0]  resp_data;

   always_comb begin
      any_val        = req0_val | req1_val;
      // Priority only matters on a tie; a lone requester always wins.
      winner         = (req0_val & req1_val) ? prio_q : req1_val;
      win_type       = winner ? req1_type    : req0_type;
      win_addr       = winner ? req1_addr    : req0_addr;
      win_data       = winner ? req1_data    : req0_data;
      win_byte_en    = winner ? req1_byte_en : req0_byte_en;
      owner_resp_rdy = owner_q ? resp1_rdy : resp0_rdy;
   end

   always_comb begin
      state_d            = state_q;
      owner_d            = owner_q;
      type_d             = type_q;
      prio_d             = prio_q;
      buf_d              = buf_q;
      req0_rdy           = 1'b0;
      req1_rdy           = 1'b0;
      resp_val           = 1'b0;
      resp_data          = '0;
      sram_read_en       = 1'b0;
      sram_read_addr     = '0;
      sram_write_en      = 1'b0;
      sram_write_byte_en = '0;
      sram_write_addr    = '0;
      sram_write_data    = '0;

      if (reset) begin
         unique case (state_q)
            StIdle: begin
               if (any_val) begin
                  req0_rdy       = ~winner;
                  req1_rdy       = winner;
                  sram_read_en   = ~win_type;
                  sram_write_en  = win_type;
                  sram_read_addr = win_addr;
                  if (win_type) begin
                     sram_write_addr    = win_addr;
                     sram_write_data    = win_data;
                     sram_write_byte_en = win_byte_en;
                  end
                  owner_d = winner;
                  type_d  = win_type;
                  prio_d  = ~winner;
                  state_d = StWait;
               end
            end
            StWait: begin
               resp_val  = 1'b1;
               resp_data = type_q ? '0 : sram_read_data;
               if (owner_resp_rdy) begin
                  state_d = StIdle;
               end else begin
                  // SRAM output is only valid this cycle, so park it until accepted.
                  buf_d   = resp_data;
                  state_d = StHold;
               end
            end
            StHold: begin
               resp_val  = 1'b1;
               resp_data = buf_q;
               if (owner_resp_rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         owner_q <= 1'b0;
         type_q  <= 1'b0;
         prio_q  <= 1'b0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         type_q  <= type_d;
         prio_q  <= prio_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      resp0_val  = resp_val & ~owner_q;
      resp1_val  = resp_val & owner_q;
      resp0_type = resp0_val & type_q;
      resp1_type = resp1_val & type_q;
      resp0_data = resp0_val ? resp_data : '0;
      resp1_data = resp1_val ? resp_data : '0;
   end

`ifndef SYNTHESIS
   a_ctrl_known: assert property (@(posedge clk) disable iff (!reset)
      !$isunknown({req0_val, req1_val, resp0_rdy, resp1_rdy}));
   a_type_known: assert property (@(posedge clk) disable iff (!reset)
      (!req0_val || !$isunknown(req0_type)) && (!req1_val || !$isunknown(req1_type)));
   a_rw_excl: assert property (@(posedge clk) disable iff (!reset)
      !(sram_read_en && sram_write_en));
   a_addr_range: assert property (@(posedge clk) disable iff (!reset)
      (!sram_read_en || 32'(sram_read_addr) < p_num_entries) &&
      (!sram_write_en || 32'(sram_write_addr) < p_num_entries));
`endif

endmodule
